axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Sequential arbiter that shares the single AXI read channel (AR/R) between the instruction cache and the data cache. It replaces a purely combinational read mux: it grants one requester at a time, registers the AR beat, and holds the grant until the final R beat completes. Sits between the two cache refill engines and the CPU's top-level AXI master port; the AW/W/B channels bypass it.

## Interface
- INST_BURST_LEN, 8'd7: arlen for cached instruction refills (beats − 1).
- DATA_BURST_LEN, 8'd7: arlen for cached data refills (beats − 1).
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- inst_arvalid_i / data_arvalid_i  in  1  read request.
- inst_araddr_i / data_araddr_i  in  32  request address.
- inst_cached_i / data_cached_i  in  1  1 = burst refill, 0 = single-beat uncached read.
- inst_arready_o / data_arready_o  out  1  request accepted.
- inst_rdata_o / data_rdata_o  out  32  read data.
- inst_rvalid_o / data_rvalid_o  out  1  read beat valid.
- inst_rlast_o / data_rlast_o  out  1  last beat.
- inst_rready_i / data_rready_i  in  1  requester accepts beat.
- arid_o  out  4;  araddr_o  out  32;  arlen_o  out  8;  arsize_o  out  3;  arburst_o  out  2;  arlock_o  out  2;  arcache_o  out  4;  arprot_o  out  3;  arvalid_o  out  1;  arready_i  in  1.
- rid_i  in  4;  rdata_i  in  32;  rresp_i  in  2;  rlast_i  in  1;  rvalid_i  in  1;  rready_o  out  1.

## Operation
- States: IDLE, ADDR, DATA. Register `owner` (0 = inst, 1 = data) and `last_owner`.
- IDLE: if exactly one arvalid is high, grant it. If both are high, grant the requester that is not `last_owner` (round-robin). Latch address, cached, and owner, then go to ADDR.
- ADDR: arvalid_o = 1, driven from registers. arid_o = 0 for inst, 1 for data. arlen_o = INST_BURST_LEN or DATA_BURST_LEN when cached, else 0. arburst_o = 2'b01 when cached, else 2'b00. arsize_o = 3'b010. arlock/arcache/arprot are 0.
- Owner's arready_o = arready_i while in ADDR; the other requester's arready_o is 0.
- arvalid_o && arready_i → DATA.
- DATA: owner's rvalid/rdata/rlast follow rvalid_i/rdata_i/rlast_i combinationally. rready_o = owner's rready_i.
- The non-owner sees rvalid = 0, rlast = 0, rdata = 0 in every state.
- rvalid_i && rready_o && rlast_i → IDLE, and last_owner ← owner.
- rresp_i is ignored. rid_i is not checked; only one transaction is ever outstanding.
- A requester keeps arvalid and address stable until its arready. Any change after the grant is ignored, because the values are already latched.

## Timing
- Reset (async assert, synchronous release): state = IDLE, arvalid_o = 0, last_owner = 1 (so inst wins the first tie), araddr_o/arlen_o/arid_o = 0. All requester outputs are 0 and rready_o = 0.
- Request seen at IDLE edge N → arvalid_o high from cycle N+1. Minimum request-to-AR latency is 1 cycle.
- arvalid_o stays high until it is accepted by arready_i, with araddr/arlen/arid held stable.
- Back-to-back: the cycle after the rlast handshake is IDLE, and a new grant raises arvalid_o one cycle later. Minimum gap between transactions is 2 cycles.
- Outside DATA: rvalid_i is not forwarded and rready_o = 0.
- Reset mid-transaction: the FSM aborts to IDLE at once. Requesters must re-issue.
- New requests arriving during ADDR/DATA are not acknowledged until the next IDLE.

## Test plan
- Inst-only cached request at 0x1FC0_0000, slave arready after 2 cycles, 8 beats → arlen_o = 7, arburst_o = 01, arid_o = 0, inst sees 8 rvalid with rlast on beat 8, data sees no rvalid; FSM returns to IDLE.
- Data uncached read at 0xBFAF_8000 → arlen_o = 0, arburst_o = 00, arid_o = 1, one beat forwarded to data with rlast = 1.
- Both request in the same cycle twice in a row from reset → inst is served first, then data (round-robin), with no beat crossing between requesters.
- Owner deasserts rready mid-burst for 3 cycles → rready_o = 0 for those 3 cycles, beat count stays 8, and no data is lost or duplicated.
- Slave holds arready low for 10 cycles → arvalid_o, araddr_o, arlen_o, and arid_o are stable throughout, even if the requester changes its address.
- aresetn pulsed low during DATA beat 3 → all outputs go to 0 asynchronously, state is IDLE, and a fresh request after release is granted normally.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - two-requester round-robin arbiter for a shared AXI read (AR/R) channel
// One transaction is in flight at a time. The grant is held from the AR beat through the final R beat.
module axi_read_arbiter #(
  parameter logic [7:0] INST_BURST_LEN = 8'd7,
  parameter logic [7:0] DATA_BURST_LEN = 8'd7
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        inst_arvalid_i,
  input  logic [31:0] inst_araddr_i,
  input  logic        inst_cached_i,
  output logic        inst_arready_o,
  output logic [31:0] inst_rdata_o,
  output logic        inst_rvalid_o,
  output logic        inst_rlast_o,
  input  logic        inst_rready_i,

  input  logic        data_arvalid_i,
  input  logic [31:0] data_araddr_i,
  input  logic        data_cached_i,
  output logic        data_arready_o,
  output logic [31:0] data_rdata_o,
  output logic        data_rvalid_o,
  output logic        data_rlast_o,
  input  logic        data_rready_i,

  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic [1:0]  arlock_o,
  output logic [3:0]  arcache_o,
  output logic [2:0]  arprot_o,
  output logic        arvalid_o,
  input  logic        arready_i,

  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        cached_q, cached_d;
  logic [31:0] addr_q, addr_d;

  logic in_addr;
  logic in_data;
  logic inst_owns;
  logic data_owns;

  // Only one transaction is ever outstanding, so response id and status carry no information here.
  logic unused_r_fields;
  assign unused_r_fields = ^{rid_i, rresp_i};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cached_d     = cached_q;
    addr_d       = addr_q;
    unique case (state_q)
      IDLE: begin
        if (inst_arvalid_i || data_arvalid_i) begin
          if (inst_arvalid_i && data_arvalid_i) begin
            owner_d = ~last_owner_q;
          end else begin
            owner_d = data_arvalid_i;
          end
          addr_d   = owner_d ? data_araddr_i : inst_araddr_i;
          cached_d = owner_d ? data_cached_i : inst_cached_i;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (arready_i) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (rvalid_i && rready_o && rlast_i) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cached_q     <= 1'b0;
      addr_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cached_q     <= cached_d;
      addr_q       <= addr_d;
    end
  end

  assign in_addr   = (state_q == ADDR);
  assign in_data   = (state_q == DATA);
  assign inst_owns = in_data && !owner_q;
  assign data_owns = in_data && owner_q;

  assign arvalid_o = in_addr;
  assign arid_o    = {3'b000, owner_q};
  assign araddr_o  = addr_q;
  assign arlen_o   = cached_q ? (owner_q ? DATA_BURST_LEN : INST_BURST_LEN) : 8'd0;
  assign arburst_o = {1'b0, cached_q};
  assign arsize_o  = 3'b010;
  assign arlock_o  = 2'b00;
  assign arcache_o = 4'b0000;
  assign arprot_o  = 3'b000;

  assign inst_arready_o = in_addr && !owner_q && arready_i;
  assign data_arready_o = in_addr && owner_q && arready_i;

  assign rready_o = in_data && (owner_q ? data_rready_i : inst_rready_i);

  // Non-owner and out-of-DATA views are forced to zero so no beat can leak across requesters.
  assign inst_rvalid_o = inst_owns && rvalid_i;
  assign inst_rlast_o  = inst_owns && rlast_i;
  assign inst_rdata_o  = inst_owns ? rdata_i : 32'd0;
  assign data_rvalid_o = data_owns && rvalid_i;
  assign data_rlast_o  = data_owns && rlast_i;
  assign data_rdata_o  = data_owns ? rdata_i : 32'd0;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - scoreboard bench for axi_read_arbiter with random slave timing
module tb_axi_read_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_arvalid_i, data_arvalid_i;
  logic [31:0] inst_araddr_i, data_araddr_i;
  logic        inst_cached_i, data_cached_i;
  logic        inst_arready_o, data_arready_o;
  logic [31:0] inst_rdata_o, data_rdata_o;
  logic        inst_rvalid_o, data_rvalid_o;
  logic        inst_rlast_o, data_rlast_o;
  logic        inst_rready_i, data_rready_i;
  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic [1:0]  arlock_o;
  logic [3:0]  arcache_o;
  logic [2:0]  arprot_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [3:0]  rid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic        rvalid_i;
  logic        rready_o;

  always #5 aclk = ~aclk;

  axi_read_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_arvalid_i(inst_arvalid_i), .inst_araddr_i(inst_araddr_i), .inst_cached_i(inst_cached_i),
    .inst_arready_o(inst_arready_o), .inst_rdata_o(inst_rdata_o), .inst_rvalid_o(inst_rvalid_o),
    .inst_rlast_o(inst_rlast_o), .inst_rready_i(inst_rready_i),
    .data_arvalid_i(data_arvalid_i), .data_araddr_i(data_araddr_i), .data_cached_i(data_cached_i),
    .data_arready_o(data_arready_o), .data_rdata_o(data_rdata_o), .data_rvalid_o(data_rvalid_o),
    .data_rlast_o(data_rlast_o), .data_rready_i(data_rready_i),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arlock_o(arlock_o), .arcache_o(arcache_o), .arprot_o(arprot_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  req_t  inst_q[$];
  req_t  data_q[$];
  beat_t beat_q[$];

  int checks   = 0;
  int failures = 0;

  // reference model: phase 0 = idle, 1 = address, 2 = data
  int   phase = 0, nxt = 0, m_beats = 0;
  bit   owner = 1'b0, nxt_owner = 1'b0, m_last = 1'b1;
  req_t cur, nxt_req;
  bit   ar_hs = 1'b0, r_hs = 1'b0;

  int ar_delay      = 0;
  bit stall_en      = 1'b0;
  int force_stall_i = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Monitor: everything sampled on the falling edge, away from the active edge.
  initial begin : monitor
    bit    own_rr;
    beat_t b;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        phase = 0; nxt = 0; m_last = 1'b1; m_beats = 0; ar_hs = 1'b0; r_hs = 1'b0;
        inst_q.delete(); data_q.delete(); beat_q.delete();
        chk("rst_arvalid", arvalid_o, 0);
        chk("rst_rready", rready_o, 0);
        chk("rst_arid_addr_len", {arid_o, araddr_o, arlen_o}, 0);
        chk("rst_req_outputs", {inst_arready_o, data_arready_o, inst_rvalid_o, data_rvalid_o,
                                inst_rlast_o, data_rlast_o, inst_rdata_o, data_rdata_o}, 0);
      end else begin
        phase = nxt;
        owner = nxt_owner;
        cur   = nxt_req;
        chk("arvalid", arvalid_o, phase == 1);
        if (phase == 1) begin
          chk("arid", arid_o, {3'b000, owner});
          chk("araddr", araddr_o, cur.addr);
          chk("arlen", arlen_o, cur.len);
          chk("arburst", arburst_o, cur.burst);
          chk("arsize", arsize_o, 3'b010);
          chk("ar_lock_cache_prot", {arlock_o, arcache_o, arprot_o}, 0);
        end
        chk("inst_arready", inst_arready_o, (phase == 1) && !owner && arready_i);
        chk("data_arready", data_arready_o, (phase == 1) && owner && arready_i);
        own_rr = owner ? data_rready_i : inst_rready_i;
        chk("rready", rready_o, (phase == 2) && own_rr);
        chk("inst_rvalid", inst_rvalid_o, (phase == 2) && !owner && rvalid_i);
        chk("data_rvalid", data_rvalid_o, (phase == 2) && owner && rvalid_i);
        if (!(phase == 2 && !owner)) chk("inst_r_idle_zero", {inst_rlast_o, inst_rdata_o}, 0);
        if (!(phase == 2 && owner))  chk("data_r_idle_zero", {data_rlast_o, data_rdata_o}, 0);
        ar_hs = arvalid_o && arready_i;
        r_hs  = rvalid_i && rready_o;
        if (phase == 2 && rvalid_i && own_rr) begin
          m_beats++;
          if (beat_q.size() == 0) begin
            fail_now("beat_with_nothing_expected");
          end else begin
            b = beat_q.pop_front();
            chk("rdata", owner ? data_rdata_o : inst_rdata_o, b.data);
          end
          chk("rlast", owner ? data_rlast_o : inst_rlast_o, m_beats == int'(cur.len) + 1);
          if (m_beats == int'(cur.len) + 1) begin
            nxt = 0; m_last = owner; m_beats = 0;
          end
        end
        if (phase == 0 && (inst_arvalid_i || data_arvalid_i)) begin
          nxt_owner = (inst_arvalid_i && data_arvalid_i) ? ~m_last : data_arvalid_i;
          nxt = 1;
          if (nxt_owner) begin
            if (data_q.size() != 0) nxt_req = data_q.pop_front();
            else fail_now("data_grant_without_request");
          end else begin
            if (inst_q.size() != 0) nxt_req = inst_q.pop_front();
            else fail_now("inst_grant_without_request");
          end
        end else if (phase == 1 && arready_i) begin
          nxt = 2;
        end
      end
    end
  end

  // Slave: random AR acceptance delay and random R-beat gaps.
  initial begin : slave
    bit    busy = 1'b0;
    int    ar_cnt = 0;
    int    s_beat = 0;
    int    s_len = 0;
    beat_t nb;
    arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0; rdata_i = 32'd0; rid_i = 4'd0; rresp_i = 2'd0;
    forever begin
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        busy = 1'b0; ar_cnt = 0; arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0;
      end else begin
        if (!busy) begin
          if (ar_hs) begin
            busy = 1'b1; s_len = int'(arlen_o); s_beat = 0; arready_i = 1'b0; ar_cnt = 0;
            rid_i = arid_o;
          end else if (arvalid_o) begin
            arready_i = (ar_cnt >= ar_delay);
            ar_cnt++;
          end else begin
            arready_i = 1'b0; ar_cnt = 0;
          end
        end
        if (busy && r_hs) begin
          rvalid_i = 1'b0; rlast_i = 1'b0;
          if (s_beat == s_len) busy = 1'b0;
          else s_beat++;
        end
        if (busy && !rvalid_i && ($urandom_range(0, 3) != 0)) begin
          rvalid_i = 1'b1;
          rdata_i  = $urandom;
          rlast_i  = (s_beat == s_len);
          rresp_i  = 2'($urandom_range(0, 3));
          nb.data  = rdata_i;
          nb.last  = rlast_i;
          beat_q.push_back(nb);
        end
        if (!rvalid_i) rdata_i = $urandom;
      end
    end
  end

  initial begin : rready_drv
    inst_rready_i = 1'b1; data_rready_i = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      inst_rready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      data_rready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (force_stall_i > 0) begin
        inst_rready_i = 1'b0;
        force_stall_i--;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  task automatic issue(input bit who, input logic [31:0] addr, input bit cached, input bit perturb);
    req_t r;
    bit   got = 1'b0;
    r.addr  = addr;
    r.len   = cached ? 8'd7 : 8'd0;
    r.burst = cached ? 2'b01 : 2'b00;
    if (who) begin
      data_q.push_back(r);
      data_araddr_i = addr; data_cached_i = cached; data_arvalid_i = 1'b1;
    end else begin
      inst_q.push_back(r);
      inst_araddr_i = addr; inst_cached_i = cached; inst_arvalid_i = 1'b1;
    end
    for (int n = 0; n < 400; n++) begin
      @(negedge aclk);
      if (who ? data_arready_o : inst_arready_o) begin
        got = 1'b1;
        break;
      end
      @(posedge aclk);
      #1;
      if (perturb && n == 3) begin
        if (who) data_araddr_i = ~addr;
        else inst_araddr_i = ~addr;
      end
    end
    @(posedge aclk);
    #1;
    if (who) data_arvalid_i = 1'b0;
    else inst_arvalid_i = 1'b0;
    chk(who ? "data_arready_seen" : "inst_arready_seen", got, 1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge aclk);
      if (phase == 0 && nxt == 0 && beat_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("return_to_idle", done, 1);
    @(posedge aclk);
    #1;
  endtask

  initial begin : main
    bit seen;
    inst_arvalid_i = 1'b0; inst_araddr_i = 32'd0; inst_cached_i = 1'b0;
    data_arvalid_i = 1'b0; data_araddr_i = 32'd0; data_cached_i = 1'b0;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_arvalid", arvalid_o, 0);
    chk("reset_araddr", araddr_o, 0);
    chk("reset_arlen_arid", {arlen_o, arid_o}, 0);
    @(posedge aclk);
    #3;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // simultaneous pair twice from reset: round-robin with inst winning the first tie
    for (int k = 0; k < 2; k++) begin
      fork
        issue(1'b0, $urandom & 32'hFFFF_FFFC, 1'b1, 1'b0);
        issue(1'b1, $urandom & 32'hFFFF_FFFC, 1'b1, 1'b0);
      join
    end
    wait_idle();

    ar_delay = 2;
    issue(1'b0, 32'h1FC0_0000, 1'b1, 1'b0);
    wait_idle();

    ar_delay = 0;
    issue(1'b1, 32'hBFAF_8000, 1'b0, 1'b0);
    wait_idle();

    // owner drops rready for 3 cycles mid-burst
    issue(1'b0, 32'h0000_1000, 1'b1, 1'b0);
    for (int n = 0; n < 200; n++) begin
      @(negedge aclk);
      if (phase == 2 && m_beats >= 3) break;
    end
    force_stall_i = 3;
    wait_idle();

    // slave stalls AR for 10 cycles while the requester moves its address
    ar_delay = 10;
    issue(1'b1, 32'h8000_0040, 1'b1, 1'b1);
    wait_idle();

    // reset asserted while beat 3 is pending
    ar_delay = 1;
    issue(1'b0, 32'h1FC0_0100, 1'b1, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge aclk);
      if (phase == 2 && m_beats == 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reached_beat3", seen, 1);
    #1;
    aresetn = 1'b0;
    #1;
    chk("async_rst_arvalid_rready", {arvalid_o, rready_o}, 0);
    chk("async_rst_inst_r", {inst_rvalid_o, inst_rlast_o, inst_rdata_o}, 0);
    chk("async_rst_ar_fields", {arid_o, araddr_o, arlen_o}, 0);
    repeat (2) @(posedge aclk);
    #3;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    issue(1'b0, 32'h1FC0_0200, 1'b0, 1'b0);
    wait_idle();

    // random traffic
    stall_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      ar_delay = $urandom_range(0, 4);
      fork
        begin
          int d = $urandom_range(0, 3);
          if ($urandom_range(0, 3) != 0) begin
            if (d > 0) begin
              repeat (d) @(posedge aclk);
              #1;
            end
            issue(1'b0, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 1'b0);
          end
        end
        begin
          int d = $urandom_range(0, 3);
          if ($urandom_range(0, 3) != 0) begin
            if (d > 0) begin
              repeat (d) @(posedge aclk);
              #1;
            end
            issue(1'b1, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 1'b0);
          end
        end
      join
    end
    stall_en = 1'b0;
    wait_idle();

    chk("inst_requests_drained", inst_q.size(), 0);
    chk("data_requests_drained", data_q.size(), 0);
    chk("beats_drained", beat_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
